// File: rtl/ddr_req_arbiter_if.sv
// ddr_req_arbiter_if: client request/return bus plus DDR command/return bus
// for the DDR request arbiter. The slave modport is the arbiter's view;
// the master modport is the surrounding environment (clients + DDR controller).
interface ddr_req_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 25,
  parameter int DATA_W = 128,
  parameter int CMD_W  = 4
);

  // Client side
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_we;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        req_ready;
  logic [DATA_W-1:0]        rd_data;
  logic [NUM_CH-1:0]        rd_valid;

  // DDR controller side
  logic [CMD_W-1:0]         cmd;
  logic                     cmd_valid;
  logic [ADDR_W-1:0]        ddr_address;
  logic [DATA_W-1:0]        ddr_wr_data;
  logic                     cmd_busy;
  logic [DATA_W-1:0]        ddr_rd_data;
  logic                     ddr_rd_valid;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output cmd_busy, ddr_rd_data, ddr_rd_valid,
    input  req_ready, rd_data, rd_valid,
    input  cmd, cmd_valid, ddr_address, ddr_wr_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  cmd_busy, ddr_rd_data, ddr_rd_valid,
    output req_ready, rd_data, rd_valid,
    output cmd, cmd_valid, ddr_address, ddr_wr_data
  );

endinterface

// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: N-channel arbiter in front of the DDR command port.
// One command is issued at a time (at most every other cycle); every read
// grant pushes its channel index into a tag FIFO so returned read data is
// steered back to the issuing client in order.
// Optional feature: define DDR_ARB_FIXED_PRIO_EN for fixed priority
// (lowest-index eligible channel wins); default is round-robin.
module ddr_req_arbiter #(
  parameter int               NUM_CH    = 4,
  parameter int               ADDR_W    = 25,
  parameter int               DATA_W    = 128,
  parameter int               CMD_W     = 4,
  parameter logic [CMD_W-1:0] CMD_RD    = 4'b0011,
  parameter logic [CMD_W-1:0] CMD_WR    = 4'b0100,
  parameter int               TAG_DEPTH = 16
) (
  input  logic                       clk_133M,
  input  logic                       rst_n_133M,
  input  logic                       init_done,
  ddr_req_arbiter_if.slave           bus,
  output logic [$clog2(TAG_DEPTH):0] tag_count,
  output logic                       err_orphan
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(TAG_DEPTH);

  logic [NUM_CH-1:0] eligible;
  logic [CH_W-1:0]   winner;
  logic              winner_we;
  logic [ADDR_W-1:0] winner_addr;
  logic [DATA_W-1:0] winner_wdata;
  logic              grant;
  logic              push;
  logic              pop;
  logic              tag_full;
  logic              tag_empty;
  logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CH_W-1:0]   head_tag;
  logic [NUM_CH-1:0] head_onehot;

  assign tag_full  = (tag_count == (PTR_W+1)'(TAG_DEPTH));
  assign tag_empty = (tag_count == '0);
  assign head_tag  = tag_mem[rd_ptr];

  // Reads are held off while the tag FIFO is full; writes never need a tag.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = bus.req_valid[i] & (bus.req_we[i] | ~tag_full);
    end
  end

  assign grant = init_done & ~bus.cmd_busy & ~bus.cmd_valid & (|eligible);

`ifdef DDR_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest-index eligible channel wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    winner = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (eligible[i]) winner = CH_W'(i);
    end
  end
`else
  logic [CH_W-1:0] last_grant;
  logic            hi_found;
  logic [CH_W-1:0] hi_win;
  logic [CH_W-1:0] lo_win;

  // Round-robin: lowest eligible channel above last_grant, else wrap to the lowest eligible overall.
  always_comb begin
    hi_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (CH_W'(i) > last_grant) begin
          hi_found = 1'b1;
          hi_win   = CH_W'(i);
        end else begin
          lo_win = CH_W'(i);
        end
      end
    end
    winner = hi_found ? hi_win : lo_win;
  end

  // Round-robin pointer; reset to the top channel so channel 0 goes first.
  always_ff @(posedge clk_133M) begin
    if (!rst_n_133M) begin
      last_grant <= CH_W'(NUM_CH-1);
    end else if (grant) begin
      last_grant <= winner;
    end
  end
`endif

  // Mux the winning channel's request fields and drive the one-hot grant.
  always_comb begin
    winner_we     = 1'b0;
    winner_addr   = '0;
    winner_wdata  = '0;
    bus.req_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (winner == CH_W'(i)) begin
        winner_we         = bus.req_we[i];
        winner_addr       = bus.req_addr[i*ADDR_W +: ADDR_W];
        winner_wdata      = bus.req_wdata[i*DATA_W +: DATA_W];
        bus.req_ready[i]  = grant;
      end
    end
  end

  assign push = grant & ~winner_we;
  assign pop  = bus.ddr_rd_valid & ~tag_empty;

  // Register the granted command for one-cycle presentation to the DDR controller.
  always_ff @(posedge clk_133M) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n_133M) begin
      bus.cmd_valid   <= 1'b0;
      bus.cmd         <= '0;
      bus.ddr_address <= '0;
      bus.ddr_wr_data <= '0;
    end else begin
      bus.cmd_valid <= grant;
      if (grant) begin
        bus.cmd         <= winner_we ? CMD_WR : CMD_RD;
        bus.ddr_address <= winner_addr;
        bus.ddr_wr_data <= winner_we ? winner_wdata : '0;
      end
    end
  end

  // Tag FIFO storage.
  always_ff @(posedge clk_133M) begin
    // NOTE: FIFO storage is not reset; entries are only read behind valid pointers, and skipping reset keeps it RAM-friendly.
    if (push) tag_mem[wr_ptr] <= winner;
  end

  // Tag FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk_133M) begin
    if (!rst_n_133M) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
    end
  end

  // Decode the head tag into the client return strobe.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      head_onehot[i] = (head_tag == CH_W'(i));
    end
  end

  // Steer returned read data to its client; flag data arriving with no tag outstanding.
  always_ff @(posedge clk_133M) begin
    if (!rst_n_133M) begin
      bus.rd_valid <= '0;
      bus.rd_data  <= '0;
      err_orphan   <= 1'b0;
    end else begin
      bus.rd_valid <= pop ? head_onehot : '0;
      if (pop) bus.rd_data <= bus.ddr_rd_data;
      if (bus.ddr_rd_valid && tag_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// tb_ddr_req_arbiter: directed self-checking bench for ddr_req_arbiter
// (NUM_CH=4, TAG_DEPTH=16). Outputs are sampled 2 time units after a
// rising edge, after inputs for the cycle have been applied.
module tb_ddr_req_arbiter;

  localparam int NUM_CH    = 4;
  localparam int ADDR_W    = 25;
  localparam int DATA_W    = 128;
  localparam int CMD_W     = 4;
  localparam int TAG_DEPTH = 16;
  localparam logic [3:0] C_RD = 4'b0011;
  localparam logic [3:0] C_WR = 4'b0100;

  logic clk_133M;
  logic rst_n_133M;
  logic init_done;
  logic [4:0] tag_count;
  logic err_orphan;

  int n_cmp = 0;
  int n_err = 0;

  ddr_req_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_W(CMD_W)) bus ();

  ddr_req_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_W(CMD_W),
    .CMD_RD(C_RD), .CMD_WR(C_WR), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .clk_133M   (clk_133M),
    .rst_n_133M (rst_n_133M),
    .init_done  (init_done),
    .bus        (bus),
    .tag_count  (tag_count),
    .err_orphan (err_orphan)
  );

  initial clk_133M = 1'b0;
  always #5 clk_133M = ~clk_133M;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_133M);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid    = '0;
    bus.req_we       = '0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.cmd_busy     = 1'b0;
    bus.ddr_rd_data  = '0;
    bus.ddr_rd_valid = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n_133M = 1'b0;
    tick();
    tick();
    rst_n_133M = 1'b1;
  endtask

  // Reset values, and no grants while init_done is low.
  task automatic test_reset();
    idle_inputs();
    init_done     = 1'b0;
    rst_n_133M    = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_we    = 4'hF;
    tick();
    tick();
    #1;
    n_cmp++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL rst_cmd_valid: got %b want 0", bus.cmd_valid); end
    n_cmp++; if (bus.cmd !== 4'h0) begin n_err++; $display("FAIL rst_cmd: got %h want 0", bus.cmd); end
    n_cmp++; if (bus.ddr_address !== 25'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", bus.ddr_address); end
    n_cmp++; if (bus.ddr_wr_data !== 128'h0) begin n_err++; $display("FAIL rst_wr_data: got %h want 0", bus.ddr_wr_data); end
    n_cmp++; if (bus.rd_valid !== 4'h0) begin n_err++; $display("FAIL rst_rd_valid: got %b want 0000", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== 128'h0) begin n_err++; $display("FAIL rst_rd_data: got %h want 0", bus.rd_data); end
    n_cmp++; if (tag_count !== 5'd0) begin n_err++; $display("FAIL rst_tag_count: got %0d want 0", tag_count); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL rst_err_orphan: got %b want 0", err_orphan); end
    rst_n_133M = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (bus.req_ready !== 4'h0) begin n_err++; $display("FAIL init_low_ready k=%0d: got %b want 0000", k, bus.req_ready); end
      n_cmp++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL init_low_cmd_valid k=%0d: got %b want 0", k, bus.cmd_valid); end
    end
    idle_inputs();
    init_done = 1'b1;
  endtask

  // All four channels write continuously: grants rotate 0,1,2,3,0 every other cycle.
  task automatic test_round_robin();
    logic [ADDR_W-1:0] addr_tab [NUM_CH];
    logic [DATA_W-1:0] data_tab [NUM_CH];
    logic [3:0] exp_ready;
    apply_reset();
    addr_tab[0] = 25'h0001000; addr_tab[1] = 25'h0002040;
    addr_tab[2] = 25'h0100080; addr_tab[3] = 25'h1FFFFC0;
    data_tab[0] = {4{32'hC0DE0000}}; data_tab[1] = {4{32'hC0DE1111}};
    data_tab[2] = {4{32'hC0DE2222}}; data_tab[3] = {4{32'hC0DE3333}};
    for (int i = 0; i < NUM_CH; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W]  = addr_tab[i];
      bus.req_wdata[i*DATA_W +: DATA_W] = data_tab[i];
    end
    bus.req_we    = 4'hF;
    bus.req_valid = 4'hF;
    #1;
    for (int k = 0; k < 10; k++) begin
      int ch;
      ch = (k / 2) % NUM_CH;
      exp_ready = (k % 2 == 0) ? 4'(1 << ch) : 4'h0;
      n_cmp++; if (bus.req_ready !== exp_ready) begin n_err++; $display("FAIL rr_ready k=%0d: got %b want %b", k, bus.req_ready, exp_ready); end
      n_cmp++; if (bus.cmd_valid !== 1'(k % 2)) begin n_err++; $display("FAIL rr_cmd_valid k=%0d: got %b want %0d", k, bus.cmd_valid, k % 2); end
      if (k % 2 == 1) begin
        n_cmp++; if (bus.ddr_address !== addr_tab[ch]) begin n_err++; $display("FAIL rr_addr k=%0d: got %h want %h", k, bus.ddr_address, addr_tab[ch]); end
        n_cmp++; if (bus.cmd !== C_WR) begin n_err++; $display("FAIL rr_cmd k=%0d: got %h want %h", k, bus.cmd, C_WR); end
        n_cmp++; if (bus.ddr_wr_data !== data_tab[ch]) begin n_err++; $display("FAIL rr_wdata k=%0d: got %h want %h", k, bus.ddr_wr_data, data_tab[ch]); end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  // Reads from ch1 then ch3, returned in order while init_done is low.
  task automatic test_read_return();
    apply_reset();
    bus.req_we = 4'h0;
    bus.req_addr[1*ADDR_W +: ADDR_W] = 25'h0000010;
    bus.req_addr[3*ADDR_W +: ADDR_W] = 25'h0000020;
    bus.req_wdata[1*DATA_W +: DATA_W] = {4{32'hDEADBEEF}};
    bus.req_valid = 4'b1010;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL rd_ready1: got %b want 0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b1000;
    #1;
    n_cmp++; if (bus.cmd_valid !== 1'b1) begin n_err++; $display("FAIL rd_cmd_valid1: got %b want 1", bus.cmd_valid); end
    n_cmp++; if (bus.cmd !== C_RD) begin n_err++; $display("FAIL rd_cmd1: got %h want %h", bus.cmd, C_RD); end
    n_cmp++; if (bus.ddr_address !== 25'h0000010) begin n_err++; $display("FAIL rd_addr1: got %h want 0000010", bus.ddr_address); end
    n_cmp++; if (bus.ddr_wr_data !== 128'h0) begin n_err++; $display("FAIL rd_wdata_zero: got %h want 0", bus.ddr_wr_data); end
    n_cmp++; if (tag_count !== 5'd1) begin n_err++; $display("FAIL rd_tag_count1: got %0d want 1", tag_count); end
    n_cmp++; if (bus.req_ready !== 4'h0) begin n_err++; $display("FAIL rd_ready_gap: got %b want 0000", bus.req_ready); end
    tick();
    n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL rd_ready3: got %b want 1000", bus.req_ready); end
    tick();
    bus.req_valid = 4'h0;
    #1;
    n_cmp++; if (bus.ddr_address !== 25'h0000020) begin n_err++; $display("FAIL rd_addr3: got %h want 0000020", bus.ddr_address); end
    n_cmp++; if (tag_count !== 5'd2) begin n_err++; $display("FAIL rd_tag_count2: got %0d want 2", tag_count); end
    init_done        = 1'b0;
    bus.ddr_rd_data  = {16{8'hAA}};
    bus.ddr_rd_valid = 1'b1;
    tick();
    bus.ddr_rd_data = {16{8'hBB}};
    #1;
    n_cmp++; if (bus.rd_valid !== 4'b0010) begin n_err++; $display("FAIL ret_valid1: got %b want 0010", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== {16{8'hAA}}) begin n_err++; $display("FAIL ret_data1: got %h want aa..", bus.rd_data); end
    n_cmp++; if (tag_count !== 5'd1) begin n_err++; $display("FAIL ret_tag_count1: got %0d want 1", tag_count); end
    tick();
    bus.ddr_rd_valid = 1'b0;
    #1;
    n_cmp++; if (bus.rd_valid !== 4'b1000) begin n_err++; $display("FAIL ret_valid3: got %b want 1000", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== {16{8'hBB}}) begin n_err++; $display("FAIL ret_data3: got %h want bb..", bus.rd_data); end
    n_cmp++; if (tag_count !== 5'd0) begin n_err++; $display("FAIL ret_tag_count0: got %0d want 0", tag_count); end
    tick();
    n_cmp++; if (bus.rd_valid !== 4'h0) begin n_err++; $display("FAIL ret_valid_off: got %b want 0000", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== {16{8'hBB}}) begin n_err++; $display("FAIL ret_data_hold: got %h want bb..", bus.rd_data); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL ret_no_orphan: got %b want 0", err_orphan); end
    init_done = 1'b1;
  endtask

  // cmd_busy high for 5 cycles blocks grants; grant appears the cycle it falls.
  task automatic test_busy();
    apply_reset();
    bus.cmd_busy  = 1'b1;
    bus.req_we    = 4'b0100;
    bus.req_addr[2*ADDR_W +: ADDR_W] = 25'h1ABCDEF;
    bus.req_valid = 4'b0100;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (bus.req_ready !== 4'h0) begin n_err++; $display("FAIL busy_ready k=%0d: got %b want 0000", k, bus.req_ready); end
      n_cmp++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL busy_cmd_valid k=%0d: got %b want 0", k, bus.cmd_valid); end
      tick();
    end
    bus.cmd_busy = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL busy_release_ready: got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'h0;
    #1;
    n_cmp++; if (bus.cmd_valid !== 1'b1) begin n_err++; $display("FAIL busy_cmd_valid_after: got %b want 1", bus.cmd_valid); end
    n_cmp++; if (bus.ddr_address !== 25'h1ABCDEF) begin n_err++; $display("FAIL busy_addr: got %h want 1abcdef", bus.ddr_address); end
  endtask

  // Fill the tag FIFO with 16 reads; reads held off, writes still granted.
  task automatic test_tag_full();
    int cycles;
    apply_reset();
    bus.req_we    = 4'h0;
    bus.req_addr[0*ADDR_W +: ADDR_W] = 25'h0000040;
    bus.req_addr[2*ADDR_W +: ADDR_W] = 25'h0000080;
    bus.req_wdata[2*DATA_W +: DATA_W] = {4{32'h12345678}};
    bus.req_valid = 4'b0001;
    #1;
    cycles = 0;
    while (tag_count < 5'd16 && cycles < 100) begin
      tick();
      cycles++;
    end
    n_cmp++; if (tag_count !== 5'd16) begin n_err++; $display("FAIL full_fill: got %0d want 16 after %0d cycles", tag_count, cycles); end
    tick();
    n_cmp++; if (bus.req_ready !== 4'h0) begin n_err++; $display("FAIL full_read_held: got %b want 0000", bus.req_ready); end
    bus.req_we    = 4'b0100;
    bus.req_valid = 4'b0101;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL full_write_grant: got %b want 0100", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0001;
    #1;
    n_cmp++; if (bus.cmd !== C_WR) begin n_err++; $display("FAIL full_write_cmd: got %h want %h", bus.cmd, C_WR); end
    n_cmp++; if (tag_count !== 5'd16) begin n_err++; $display("FAIL full_count_write: got %0d want 16", tag_count); end
    tick();
    n_cmp++; if (bus.req_ready !== 4'h0) begin n_err++; $display("FAIL full_read_held2: got %b want 0000", bus.req_ready); end
    bus.ddr_rd_data  = {16{8'h5A}};
    bus.ddr_rd_valid = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 4'h0) begin n_err++; $display("FAIL full_pop_cycle_ready: got %b want 0000", bus.req_ready); end
    tick();
    bus.ddr_rd_valid = 1'b0;
    #1;
    n_cmp++; if (bus.rd_valid !== 4'b0001) begin n_err++; $display("FAIL full_ret_valid: got %b want 0001", bus.rd_valid); end
    n_cmp++; if (tag_count !== 5'd15) begin n_err++; $display("FAIL full_count15: got %0d want 15", tag_count); end
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL full_read_regrant: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'h0;
    #1;
    n_cmp++; if (bus.cmd !== C_RD) begin n_err++; $display("FAIL full_read_cmd: got %h want %h", bus.cmd, C_RD); end
    n_cmp++; if (tag_count !== 5'd16) begin n_err++; $display("FAIL full_refill: got %0d want 16", tag_count); end
    bus.ddr_rd_valid = 1'b1;
    repeat (16) tick();
    bus.ddr_rd_valid = 1'b0;
    #1;
    n_cmp++; if (tag_count !== 5'd0) begin n_err++; $display("FAIL full_drain: got %0d want 0", tag_count); end
    n_cmp++; if (bus.rd_valid !== 4'b0001) begin n_err++; $display("FAIL full_drain_valid: got %b want 0001", bus.rd_valid); end
    n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL full_no_orphan: got %b want 0", err_orphan); end
  endtask

  // Read grant (push) and read return (pop) in the same cycle.
  task automatic test_push_pop();
    apply_reset();
    bus.req_we    = 4'h0;
    bus.req_valid = 4'b0001;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL pp_ready0: got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'h0;
    tick();
    bus.req_valid    = 4'b0010;
    bus.ddr_rd_data  = {16{8'h33}};
    bus.ddr_rd_valid = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL pp_ready1: got %b want 0010", bus.req_ready); end
    tick();
    bus.req_valid    = 4'h0;
    bus.ddr_rd_valid = 1'b0;
    #1;
    n_cmp++; if (tag_count !== 5'd1) begin n_err++; $display("FAIL pp_count: got %0d want 1", tag_count); end
    n_cmp++; if (bus.rd_valid !== 4'b0001) begin n_err++; $display("FAIL pp_ret0: got %b want 0001", bus.rd_valid); end
    n_cmp++; if (bus.cmd_valid !== 1'b1) begin n_err++; $display("FAIL pp_cmd_valid: got %b want 1", bus.cmd_valid); end
    bus.ddr_rd_data  = {16{8'h44}};
    bus.ddr_rd_valid = 1'b1;
    tick();
    bus.ddr_rd_valid = 1'b0;
    #1;
    n_cmp++; if (bus.rd_valid !== 4'b0010) begin n_err++; $display("FAIL pp_ret1: got %b want 0010", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== {16{8'h44}}) begin n_err++; $display("FAIL pp_data1: got %h want 44..", bus.rd_data); end
    n_cmp++; if (tag_count !== 5'd0) begin n_err++; $display("FAIL pp_count0: got %0d want 0", tag_count); end
  endtask

  // Read data with nothing outstanding: dropped, sticky err_orphan until reset.
  task automatic test_orphan();
    apply_reset();
    bus.ddr_rd_data  = {16{8'h77}};
    bus.ddr_rd_valid = 1'b1;
    tick();
    bus.ddr_rd_valid = 1'b0;
    #1;
    n_cmp++; if (bus.rd_valid !== 4'h0) begin n_err++; $display("FAIL orphan_rd_valid: got %b want 0000", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== 128'h0) begin n_err++; $display("FAIL orphan_rd_data: got %h want 0", bus.rd_data); end
    n_cmp++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_set: got %b want 1", err_orphan); end
    repeat (3) tick();
    n_cmp++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
    rst_n_133M = 1'b0;
    tick();
    n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL orphan_clear: got %b want 0", err_orphan); end
    rst_n_133M = 1'b1;
  endtask

  // Channels 0 and 2 write continuously: alternate under round-robin, ch0 always under fixed priority.
  task automatic test_two_ch();
    logic [3:0] exp_ready;
    apply_reset();
    bus.req_we    = 4'b0101;
    bus.req_valid = 4'b0101;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) begin
        exp_ready = 4'h0;
      end else begin
`ifdef DDR_ARB_FIXED_PRIO_EN
        exp_ready = 4'b0001;
`else
        exp_ready = ((k / 2) % 2 == 0) ? 4'b0001 : 4'b0100;
`endif
      end
      n_cmp++; if (bus.req_ready !== exp_ready) begin n_err++; $display("FAIL two_ch_ready k=%0d: got %b want %b", k, bus.req_ready, exp_ready); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read_return();
    test_busy();
    test_tag_full();
    test_push_pop();
    test_orphan();
    test_two_ch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_req_arbiter.md
Name: ddr_req_arbiter

Overview:
- Parametrised N-channel arbiter between client modules (camera, VGA, HDR, UART, ...) and the DDR command interface.
- Each channel owns a valid/ready request port. A round-robin arbiter issues one DDR command at a time.
- A tag FIFO records the issuing channel of every read, so returned read data is steered to the correct client in order.
- Replaces fixed-case request sorting: any number of simultaneous requests is accepted without a global busy.

Parameters:
- NUM_CH, 4: number of client channels (2..8).
- ADDR_W, 25: DDR address width.
- DATA_W, 128: DDR data width.
- CMD_W, 4: command field width.
- CMD_RD, 4'b0011: read command code.
- CMD_WR, 4'b0100: write command code.
- TAG_DEPTH, 16: outstanding-read tag FIFO depth (power of 2).

Ports:
- clk_133M  in  1  system clock
- rst_n_133M  in  1  reset, synchronous, active-low
- init_done  in  1  DDR controller initialised; no grants while low
- req_valid  in  NUM_CH  per-channel request valid
- req_we  in  NUM_CH  1 = write, 0 = read
- req_addr  in  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*DATA_W  packed write data
- req_ready  out  NUM_CH  one-hot grant; handshake completes when valid & ready
- rd_data  out  DATA_W  returned read data (shared by all channels)
- rd_valid  out  NUM_CH  one-hot; rd_data belongs to channel i
- cmd  out  CMD_W  DDR command
- cmd_valid  out  1  command strobe
- ddr_address  out  ADDR_W  DDR address
- ddr_wr_data  out  DATA_W  DDR write data
- cmd_busy  in  1  DDR controller cannot accept a command
- ddr_rd_data  in  DATA_W  DDR read data
- ddr_rd_valid  in  1  read data strobe
- tag_count  out  log2(TAG_DEPTH)+1  outstanding reads
- err_orphan  out  1  sticky: read data arrived with no outstanding tag

Behaviour:
- Reset values: all outputs 0. Arbiter pointer last_grant = NUM_CH-1, so channel 0 is first after reset. Tag FIFO empty.
- Eligibility: channel i is eligible when req_valid[i] is high and (req_we[i] is high or the tag FIFO is not full).
- Grant condition: init_done & ~cmd_busy & ~cmd_valid & (at least one eligible channel).
  - The winner is the first eligible channel searching from last_grant+1 upward, wrapping modulo NUM_CH.
  - req_ready is combinational from registered state plus current inputs. At most one bit is high; none is high when the grant condition fails.
- Issue: in the cycle after a grant, cmd_valid = 1 for exactly one cycle.
  - cmd = CMD_WR or CMD_RD; ddr_address and ddr_wr_data are registered from the winner.
  - ddr_wr_data = 0 for reads.
  - last_grant updates to the winner.
  - Maximum issue rate: one command every 2 cycles.
- Read tagging: a read grant pushes the winner index into the tag FIFO in the grant cycle.
- Read return: on ddr_rd_valid with the FIFO not empty, pop the head tag.
  - Next cycle: rd_data = ddr_rd_data and rd_valid[tag] = 1 for one cycle; rd_data holds afterwards.
  - Latency: 1 cycle.
- Simultaneous push and pop in the same cycle: both take effect; tag_count is unchanged.
- ddr_rd_valid with the FIFO empty: data dropped, no rd_valid, err_orphan set. err_orphan clears only on reset.
- Tag FIFO full: read requests are held off with req_ready low, while writes continue to be granted. No overflow is possible.
- init_done low: no grants. Pending returns are still routed.
- Reset mid-operation: everything returns to reset values on the next edge. In-flight DDR reads then produce err_orphan; the integrator must reset the DDR controller together with this block.

Optional Feature:
- Macro DDR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index eligible channel always wins and last_grant is unused. Suited to a camera-first policy on channel 0.
- Undefined: round-robin as above.

Test Plan:
- NUM_CH=4, channels 0..3 all write-valid continuously, cmd_busy=0 -> grants in order 0,1,2,3,0; cmd_valid every other cycle; ddr_address equals each channel's address.
- Channel 1 read at addr 0x0000010, then channel 3 read at 0x0000020; DDR returns 0xAA.., then 0xBB.. -> rd_valid=4'b0010 with 0xAA.., then rd_valid=4'b1000 with 0xBB..; tag_count goes 2, 1, 0.
- cmd_busy held high for 5 cycles with requests pending -> no req_ready, no cmd_valid; first grant appears in the cycle cmd_busy falls.
- TAG_DEPTH=16, 16 reads outstanding, channel 0 read plus channel 2 write both valid -> only channel 2 granted; after one ddr_rd_valid, channel 0 granted.
- ddr_rd_valid pulse with no reads issued -> no rd_valid; err_orphan=1 until rst_n_133M=0.
- With DDR_ARB_FIXED_PRIO_EN defined, channels 0 and 2 both valid continuously -> channel 0 granted every issue slot.
